// File: rtl/sort_pkg.sv
// Shared types and defaults for the in-place RAM sorter: controller state
// encoding plus the default sort size and counter widths.
package sort_pkg;

  localparam int K_DEF  = 16;
  localparam int SW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT_I = 4'd1,
    LD_A   = 4'd2,
    LD_B   = 4'd3,
    CMP    = 4'd4,
    WR_I   = 4'd5,
    WR_J   = 4'd6,
    RLD_A  = 4'd7,
    INC_J  = 4'd8,
    INC_I  = 4'd9,
    DONE   = 4'd10
  } state_t;

endpackage

// File: rtl/sort_datapath.sv
// Sorter datapath: K-word RAM, i/j address counters, A/B compare registers and
// an external port for loading and reading the RAM while the sorter is idle.
module sort_datapath
  import sort_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          Li,
  input  logic          Ei,
  input  logic          Lj,
  input  logic          Ej,
  input  logic          EA,
  input  logic          EB,
  input  logic          Csel,
  input  logic          Bout,
  input  logic          Wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_we,
  output logic          zi,
  output logic          zj,
  output logic          AgtB,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [K];
  logic [AW-1:0] r_i;
  logic [AW-1:0] r_j;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic [DW-1:0] w_rdata;

  // While sorting, the controller owns address, write data and write enable.
  assign w_addr  = start ? (Csel ? r_j : r_i) : i_addr;
  assign w_wdata = start ? (Bout ? r_b : r_a) : i_wdata;
  assign w_we    = start ? Wr : i_we;
  assign w_rdata = r_mem[w_addr];

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (Li) begin
        r_i <= '0;
      end else if (Ei) begin
        r_i <= r_i + AW'(1);
      end
      if (Lj) begin
        r_j <= r_i + AW'(1);
      end else if (Ej) begin
        r_j <= r_j + AW'(1);
      end
      if (EA) begin
        r_a <= w_rdata;
      end
      if (EB) begin
        r_b <= w_rdata;
      end
    end
  end

  assign zi      = (r_i == AW'(K - 2));
  assign zj      = (r_j == AW'(K - 1));
  assign AgtB    = (r_a > r_b);
  assign o_rdata = w_rdata;

endmodule

// File: rtl/sort_top.sv
// Sorter top: controller and datapath joined, with the datapath flags fed
// back to the controller and the RAM port exposed for load/readback.
module sort_top
  import sort_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int SW = SW_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_we,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic [SW-1:0] o_swap_cnt
);

  logic w_zi, w_zj, w_agtb;
  logic w_busy, w_li, w_ei, w_lj, w_ej, w_ea, w_eb, w_csel, w_bout, w_wr;

  sort_controller #(.K(K), .SW(SW)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .s        (s),
    .zi       (w_zi),
    .zj       (w_zj),
    .AgtB     (w_agtb),
    .busy     (w_busy),
    .Li       (w_li),
    .Ei       (w_ei),
    .Lj       (w_lj),
    .Ej       (w_ej),
    .EA       (w_ea),
    .EB       (w_eb),
    .Csel     (w_csel),
    .Bout     (w_bout),
    .Wr       (w_wr),
    .done     (o_done),
    .swap_cnt (o_swap_cnt)
  );

  sort_datapath #(.K(K), .DW(DW), .AW(AW)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .start   (w_busy),
    .Li      (w_li),
    .Ei      (w_ei),
    .Lj      (w_lj),
    .Ej      (w_ej),
    .EA      (w_ea),
    .EB      (w_eb),
    .Csel    (w_csel),
    .Bout    (w_bout),
    .Wr      (w_wr),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_we    (i_we),
    .zi      (w_zi),
    .zj      (w_zj),
    .AgtB    (w_agtb),
    .o_rdata (o_rdata)
  );

  assign o_busy = w_busy;

endmodule

// File: rtl/sort_controller.sv
// Exchange-sort control FSM: sequences the i/j counters, the A/B registers and
// RAM swaps, and counts how many swaps the current sort has performed.
module sort_controller
  import sort_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s,
  input  logic          zi,
  input  logic          zj,
  input  logic          AgtB,
  output logic          busy,
  output logic          Li,
  output logic          Ei,
  output logic          Lj,
  output logic          Ej,
  output logic          EA,
  output logic          EB,
  output logic          Csel,
  output logic          Bout,
  output logic          Wr,
  output logic          done,
  output logic [SW-1:0] swap_cnt
);

  // A full sort never exceeds K(K-1)/2 swaps, so a count that reaches that
  // bound (or all-ones for a narrow counter) can simply hold.
  localparam longint MAX_SWAPS = longint'(K) * longint'(K - 1) / 64'sd2;
  localparam longint ALL_ONES  = (64'sd1 <<< SW) - 64'sd1;
  localparam logic [SW-1:0] SWAP_CAP =
    (MAX_SWAPS >= ALL_ONES) ? {SW{1'b1}} : SW'(MAX_SWAPS);

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_swap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_swap_cnt <= '0;
    end else if ((r_state == IDLE) && s) begin
      r_swap_cnt <= '0;
    end else if ((r_state == WR_J) && (r_swap_cnt != SWAP_CAP)) begin
      r_swap_cnt <= r_swap_cnt + SW'(1);
    end else begin
      r_swap_cnt <= r_swap_cnt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s ? INIT_I : IDLE;
      INIT_I:  w_next = LD_A;
      LD_A:    w_next = LD_B;
      LD_B:    w_next = CMP;
      CMP:     w_next = AgtB ? WR_I : INC_J;
      WR_I:    w_next = WR_J;
      WR_J:    w_next = RLD_A;
      RLD_A:   w_next = INC_J;
      INC_J:   w_next = zj ? INC_I : LD_B;
      INC_I:   w_next = zi ? DONE : LD_A;
      DONE:    w_next = s ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore decode; only Ej/Ei look at the terminal-count flags.
  always_comb begin
    busy = 1'b1;
    Li   = 1'b0;
    Ei   = 1'b0;
    Lj   = 1'b0;
    Ej   = 1'b0;
    EA   = 1'b0;
    EB   = 1'b0;
    Csel = 1'b0;
    Bout = 1'b0;
    Wr   = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE:   busy = 1'b0;
      INIT_I: Li = 1'b1;
      LD_A: begin
        EA = 1'b1;
        Lj = 1'b1;
      end
      LD_B: begin
        Csel = 1'b1;
        EB   = 1'b1;
      end
      CMP:    busy = 1'b1;
      WR_I: begin
        Bout = 1'b1;
        Wr   = 1'b1;
      end
      WR_J: begin
        Csel = 1'b1;
        Wr   = 1'b1;
      end
      RLD_A:  EA = 1'b1;
      INC_J:  Ej = ~zj;
      INC_I:  Ei = ~zi;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign swap_cnt = r_swap_cnt;

endmodule

// File: tb/tb_sort_controller.sv
// Bench for sort_controller driving the sorter datapath; results are checked
// against an array-level exchange-sort reference model.
module tb_sort_controller;
  import sort_pkg::*;

  localparam int K  = 16;
  localparam int SW = 8;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s;
  logic          zi, zj, AgtB;
  logic          busy, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, done;
  logic [SW-1:0] swap_cnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          we;

  int checks    = 0;
  int failures  = 0;
  int viol      = 0;
  int wr_cycles = 0;

  logic [DW-1:0] mdl_in [K];
  logic [DW-1:0] mdl    [K];
  int            mdl_swaps;

  always #5 clk = ~clk;

  sort_controller #(.K(K), .SW(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s),
    .zi       (zi),
    .zj       (zj),
    .AgtB     (AgtB),
    .busy     (busy),
    .Li       (Li),
    .Ei       (Ei),
    .Lj       (Lj),
    .Ej       (Ej),
    .EA       (EA),
    .EB       (EB),
    .Csel     (Csel),
    .Bout     (Bout),
    .Wr       (Wr),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  sort_datapath #(.K(K), .DW(DW), .AW(AW)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .start   (busy),
    .Li      (Li),
    .Ei      (Ei),
    .Lj      (Lj),
    .Ej      (Ej),
    .EA      (EA),
    .EB      (EB),
    .Csel    (Csel),
    .Bout    (Bout),
    .Wr      (Wr),
    .i_addr  (addr),
    .i_wdata (wdata),
    .i_we    (we),
    .zi      (zi),
    .zj      (zj),
    .AgtB    (AgtB),
    .o_rdata (rdata)
  );

  // Per-cycle control-output invariants and write-cycle count.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if ((Li && Ei) || (Lj && Ej) || (Wr && (EA || EB))) viol++;
      if (!busy && (Li || Ei || Lj || Ej || EA || EB || Csel || Bout || Wr)) viol++;
      if (Wr) wr_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain exchange sort over an array, counting swaps.
  task automatic model();
    logic [DW-1:0] t;
    for (int k = 0; k < K; k++) mdl[k] = mdl_in[k];
    mdl_swaps = 0;
    for (int a = 0; a < K - 1; a++) begin
      for (int b = a + 1; b < K; b++) begin
        if (mdl[a] > mdl[b]) begin
          t      = mdl[a];
          mdl[a] = mdl[b];
          mdl[b] = t;
          mdl_swaps++;
        end
      end
    end
  endtask

  task automatic load();
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      addr  = AW'(k);
      wdata = mdl_in[k];
      we    = 1'b1;
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic run_sort(input string tag, input bit hold);
    int            cyc;
    int            inv;
    logic [DW-1:0] rd [K];
    model();
    viol      = 0;
    wr_cycles = 0;
    @(negedge clk);
    s = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    if (!hold) s = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("%s_cycles", tag), 32'(cyc), 32'(391 + 3 * mdl_swaps));
    chk($sformatf("%s_swap_cnt", tag), 32'(swap_cnt), 32'(mdl_swaps));
    chk($sformatf("%s_wr_cycles", tag), 32'(wr_cycles), 32'(2 * mdl_swaps));
    chk($sformatf("%s_invariants", tag), 32'(viol), 32'd0);
    if (hold) begin
      for (int n = 0; n < 5; n++) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s_hold_done", tag), {30'd0, done, busy}, 32'd2);
      end
      s = 1'b0;
    end
    @(posedge clk);
    #1;
    chk($sformatf("%s_idle", tag), {30'd0, done, busy}, 32'd0);
    inv = 0;
    for (int k = 0; k < K; k++) begin
      addr = AW'(k);
      #1;
      rd[k] = rdata;
      chk($sformatf("%s_ram%0d", tag, k), 32'(rd[k]), 32'(mdl[k]));
    end
    for (int k = 0; k < K - 1; k++) if (rd[k] > rd[k + 1]) inv++;
    chk($sformatf("%s_ascending", tag), 32'(inv), 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    rst   = 1'b0;
    s     = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    #12;
    chk("reset_outputs", {21'd0, busy, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, done}, 32'd0);
    chk("reset_swap_cnt", 32'(swap_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, done, busy}, 32'd0);

    for (int k = 0; k < K; k++) mdl_in[k] = DW'(k);
    load();
    run_sort("ascending", 1'b0);

    for (int k = 0; k < K; k++) mdl_in[k] = DW'(K - 1 - k);
    load();
    run_sort("descending", 1'b0);

    for (int k = 0; k < K; k++) mdl_in[k] = 16'h00AA;
    load();
    run_sort("const_aa", 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < K; k++) mdl_in[k] = DW'($urandom_range(0, 7));
      load();
      run_sort($sformatf("rand_dup%0d", r), 1'b0);
    end

    for (int k = 0; k < K; k++) mdl_in[k] = DW'($urandom & 32'h0000_FFFF);
    load();
    run_sort("rand_wide", 1'b0);

    // Reset in the third WR_J of a descending sort.
    for (int k = 0; k < K; k++) mdl_in[k] = DW'(K - 1 - k);
    load();
    @(negedge clk);
    s = 1'b1;
    @(posedge clk);
    #1;
    s   = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (Wr && Csel && !Bout) n++;
    end
    chk("rst_reached_wrj", 32'(n), 32'd3);
    chk("pre_rst_swap_cnt", 32'(swap_cnt), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("midsort_rst_outputs", {21'd0, busy, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, done}, 32'd0);
    chk("midsort_rst_swap_cnt", 32'(swap_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("no_start_without_s", {30'd0, done, busy}, 32'd0);
    end
    for (int k = 0; k < K; k++) mdl_in[k] = DW'($urandom_range(0, 15));
    load();
    run_sort("after_rst", 1'b0);

    for (int k = 0; k < K; k++) mdl_in[k] = DW'($urandom_range(0, 31));
    load();
    run_sort("hold_s", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_controller.md
SORT_CONTROLLER -- requirements
Module: sort_controller

Interface
REQ-001 Parameter K, default 16: number of RAM words sorted; must match the datapath counter limits.
REQ-002 Parameter SW, default 8: width of swap_cnt.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 s  in  1  sort request, level-sensitive.
REQ-006 zi  in  1  datapath flag: counter i == K-2.
REQ-007 zj  in  1  datapath flag: counter j == K-1.
REQ-008 AgtB  in  1  datapath flag: register A > register B, unsigned.
REQ-009 busy  out  1  drives the datapath start input; selects counter addressing and swap write data.
REQ-010 Li, Ei, Lj, Ej  out  1 each  counter i load-to-0 and increment, counter j load-with-i+1 and increment.
REQ-011 EA, EB  out  1 each  register A and register B load enables from RAM output.
REQ-012 Csel  out  1  address select: 0 selects i, 1 selects j.
REQ-013 Bout  out  1  write-data select: 0 selects A, 1 selects B.
REQ-014 Wr  out  1  RAM write enable for the sort pass.
REQ-015 done  out  1  sort complete.
REQ-016 swap_cnt  out  SW  number of swaps in the current or last sort.

Function
REQ-017 Datapath contract: RAM read data is valid in the same cycle its address is presented; a register enable captures it at the next edge.
REQ-018 States are IDLE, INIT_I, LD_A, LD_B, CMP, WR_I, WR_J, RLD_A, INC_J, INC_I, DONE.
REQ-019 IDLE: all control outputs are 0; s=1 -> INIT_I and swap_cnt clears to 0.
REQ-020 INIT_I: Li=1 -> LD_A.
REQ-021 LD_A: Csel=0, EA=1, Lj=1 -> LD_B.
REQ-022 LD_B: Csel=1, EB=1 -> CMP.
REQ-023 CMP: no enables; AgtB=1 -> WR_I; AgtB=0 -> INC_J.
REQ-024 WR_I: Csel=0, Bout=1, Wr=1 -> WR_J.
REQ-025 WR_J: Csel=1, Bout=0, Wr=1, swap_cnt+1 saturating at all-ones -> RLD_A.
REQ-026 RLD_A: Csel=0, EA=1, which reloads A with the new M[i] -> INC_J.
REQ-027 INC_J: zj=1 -> INC_I with Ej=0; zj=0 -> Ej=1 and -> LD_B.
REQ-028 INC_I: zi=1 -> DONE with Ei=0; zi=0 -> Ei=1 and -> LD_A.
REQ-029 DONE: done=1 and all other control outputs 0; stays in DONE while s=1; s=0 -> IDLE.
REQ-030 busy=1 in every state except IDLE and DONE.
REQ-031 s is ignored while busy; s held high across DONE does not restart the sort.
REQ-032 All outputs except Ej and Ei are Moore (decoded from state); Ej and Ei also depend on zj and zi respectively.
REQ-033 Latency from INIT_I entry to DONE entry = 1 + 2(K-1) + 3K(K-1)/2 + 3*swaps cycles; 391 + 3*swaps for K=16.
REQ-034 At most one of Li/Ei and at most one of Lj/Ej is asserted in any cycle.
REQ-035 Wr and EA/EB are never asserted in the same cycle.

Reset
REQ-036 rst=0 forces IDLE immediately, regardless of clock; all outputs and swap_cnt go to 0, including mid-sort.
REQ-037 After rst deasserts, no sort starts until s=1 is sampled in IDLE.

Structure
REQ-038 A shared package sort_pkg holds the state enum type and default constants K=16 and SW=8; the datapath and controller both import it.
REQ-039 The controller is a single module (next-state logic, output decode, swap counter) with no sub-modules.
REQ-040 A top-level sort_top instantiates sort_controller and the datapath; zi, zj and AgtB are fed back from the datapath.

Verification
REQ-041 Preload 0..15 ascending, pulse s -> done after 391 cycles, Wr never asserted, swap_cnt=0.
REQ-042 Preload 15..0 descending, run -> RAM reads 0..15 ascending, done asserted, cycles = 391 + 3*swap_cnt.
REQ-043 Preload all 16 words = 0x00AA -> no swaps, 391 cycles, contents unchanged.
REQ-044 Random data with duplicates -> output ascending and a permutation of the input; swap_cnt matches a reference model.
REQ-045 Assert rst=0 while in WR_J -> outputs 0 immediately, state IDLE; a new s pulse then sorts correctly.
REQ-046 Hold s=1 through DONE -> done stays 1 with no restart; drop s -> IDLE next edge.
